// File: rtl/snes_reader.sv
// snes_reader: console-side SNES pad master; drives latch/clock, shifts in a 16-bit button word
// bit 15 arrives first and is valid directly after the latch pulse
module snes_reader #(
   parameter int LATCH_CYCLES = 600,
   parameter int HALF_CYCLES  = 300,
   parameter int POLL_CYCLES  = 833333,
   parameter int INVERT_DATA  = 0
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic        auto_en,
   input  logic        SNES_data,
   output logic        SNES_latch,
   output logic        SNES_clk,
   output logic [15:0] buttons,
   output logic        valid,
   output logic        busy
);
   localparam int CW = $clog2(LATCH_CYCLES > HALF_CYCLES ? LATCH_CYCLES : HALF_CYCLES);
   localparam int PW = $clog2(POLL_CYCLES);
   typedef enum logic [2:0] {IDLE, LATCH, HIGH, LOW, DONE} state_t;
   state_t state, state_nx;
   logic [CW-1:0] cnt, cnt_nx;
   logic [3:0] bit_idx, bit_nx;
   logic [15:0] shift, word;
   logic [PW-1:0] poll;
   logic [1:0] sync;
   logic tick, req, last_half;
   assign tick = poll == PW'(POLL_CYCLES - 1);
   assign req = start | (auto_en & tick);
   assign last_half = cnt == CW'(HALF_CYCLES - 1);
   assign word = {shift[15:1], sync[1]};
   always_comb begin
      state_nx = state;
      cnt_nx = cnt + 1'b1;
      bit_nx = bit_idx;
      case (state)
         IDLE: begin
            cnt_nx = '0;
            if (req) state_nx = LATCH;
         end
         LATCH: if (cnt == CW'(LATCH_CYCLES - 1)) begin
            state_nx = HIGH;
            cnt_nx = '0;
            bit_nx = 4'd15;
         end
         HIGH: if (last_half) begin
            cnt_nx = '0;
            state_nx = bit_idx == 4'd0 ? DONE : LOW;
            bit_nx = bit_idx == 4'd0 ? bit_idx : bit_idx - 1'b1;
         end
         LOW: if (last_half) begin
            cnt_nx = '0;
            state_nx = HIGH;
         end
         default: begin
            cnt_nx = '0;
            state_nx = IDLE;
         end
      endcase
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         cnt <= '0;
         bit_idx <= '0;
         shift <= '0;
         poll <= '0;
         sync <= '0;
         buttons <= '0;
         valid <= 1'b0;
         busy <= 1'b0;
         SNES_latch <= 1'b0;
         SNES_clk <= 1'b1;
      end else begin
         state <= state_nx;
         cnt <= cnt_nx;
         bit_idx <= bit_nx;
         poll <= tick ? '0 : poll + 1'b1;
         sync <= {sync[0], SNES_data};
         if (state == HIGH && last_half) shift[bit_idx] <= sync[1];
         // word is published on entry to DONE so valid and buttons change together
         if (state == HIGH && last_half && bit_idx == 4'd0) buttons <= INVERT_DATA != 0 ? ~word : word;
         valid <= state_nx == DONE;
         busy <= state_nx != IDLE;
         SNES_latch <= state_nx == LATCH;
         SNES_clk <= state_nx != LOW;
      end
   end
endmodule

// File: tb/tb_snes_reader.sv
// tb_snes_reader: directed bench with behavioural SNES pad models on a normal and an inverting reader
module tb_snes_reader;
   logic clk = 1'b0, reset_n = 1'b0, start = 1'b0, auto_en = 1'b0, start2 = 1'b0;
   logic latch, sclk, valid, busy, latch2, sclk2, valid2, busy2;
   logic [15:0] buttons, buttons2;
   logic [15:0] pad = 16'h0, pad2 = 16'h0, sr = 16'h0, sr2 = 16'h0;
   int tests = 0, fails = 0;
   always #5 clk = ~clk;
   snes_reader #(.LATCH_CYCLES(4), .HALF_CYCLES(3), .POLL_CYCLES(200), .INVERT_DATA(0)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .auto_en(auto_en), .SNES_data(sr[15]),
      .SNES_latch(latch), .SNES_clk(sclk), .buttons(buttons), .valid(valid), .busy(busy));
   snes_reader #(.LATCH_CYCLES(4), .HALF_CYCLES(3), .POLL_CYCLES(200), .INVERT_DATA(1)) dut_inv (
      .clk(clk), .reset_n(reset_n), .start(start2), .auto_en(1'b0), .SNES_data(sr2[15]),
      .SNES_latch(latch2), .SNES_clk(sclk2), .buttons(buttons2), .valid(valid2), .busy(busy2));
   // pad model: parallel load while latch rises, shift toward bit 15 on falling SNES_clk
   always @(posedge latch or negedge sclk) sr <= latch ? pad : {sr[14:0], 1'b0};
   always @(posedge latch2 or negedge sclk2) sr2 <= latch2 ? pad2 : {sr2[14:0], 1'b0};
   task automatic frame(input int stray_at, input int chg_at, input logic [15:0] chg_word,
                        output int v_at, output int lat, output int falls, output int lows,
                        output int nvalid, output logic changed);
      logic prev;
      logic [15:0] b0;
      v_at = -1; lat = 0; falls = 0; lows = 0; nvalid = 0; changed = 1'b0; prev = 1'b1;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      b0 = buttons;
      for (int i = 0; i < 130; i++) begin
         if (i == stray_at) start = 1'b1;
         else if (i == stray_at + 1) start = 1'b0;
         if (i == chg_at) pad = chg_word;
         lat += int'(latch);
         lows += int'(!sclk);
         falls += int'(prev && !sclk);
         prev = sclk;
         if (valid) begin
            nvalid++;
            if (v_at < 0) v_at = i;
         end
         if (!valid && nvalid == 0 && buttons !== b0) changed = 1'b1;
         @(negedge clk);
      end
   endtask
   task automatic test_reset;
      repeat (3) @(negedge clk);
      tests++; if (latch !== 1'b0) begin fails++; $display("FAIL reset_latch got %b want 0", latch); end
      tests++; if (sclk !== 1'b1) begin fails++; $display("FAIL reset_sclk got %b want 1", sclk); end
      tests++; if (buttons !== 16'h0) begin fails++; $display("FAIL reset_buttons got %h want 0000", buttons); end
      tests++; if ({valid, busy} !== 2'b00) begin fails++; $display("FAIL reset_valid_busy got %b want 00", {valid, busy}); end
      reset_n = 1'b1;
   endtask
   task automatic test_basic;
      int v_at, lat, falls, lows, nv;
      logic ch;
      pad = 16'hA5C3;
      frame(-10, -1, 16'h0, v_at, lat, falls, lows, nv, ch);
      tests++; if (lat != 4) begin fails++; $display("FAIL basic_latch_cycles got %0d want 4", lat); end
      tests++; if (falls != 15) begin fails++; $display("FAIL basic_falls got %0d want 15", falls); end
      tests++; if (lows != 45) begin fails++; $display("FAIL basic_low_cycles got %0d want 45", lows); end
      tests++; if (v_at != 97) begin fails++; $display("FAIL basic_valid_at got %0d want 97", v_at); end
      tests++; if (nv != 1) begin fails++; $display("FAIL basic_valid_count got %0d want 1", nv); end
      tests++; if (buttons !== 16'hA5C3) begin fails++; $display("FAIL basic_buttons got %h want a5c3", buttons); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL basic_busy_end got %b want 0", busy); end
   endtask
   task automatic test_invert;
      int n;
      pad2 = 16'hFFFE;
      n = 0;
      @(negedge clk); start2 = 1'b1;
      @(negedge clk); start2 = 1'b0;
      while (!valid2 && n < 200) begin @(negedge clk); n++; end
      tests++; if (n != 97) begin fails++; $display("FAIL invert_valid_at got %0d want 97", n); end
      tests++; if (buttons2 !== 16'h0001) begin fails++; $display("FAIL invert_buttons got %h want 0001", buttons2); end
   endtask
   task automatic test_busy_drop;
      int v_at, lat, falls, lows, nv;
      logic ch;
      pad = 16'h3C5A;
      frame(50, -1, 16'h0, v_at, lat, falls, lows, nv, ch);
      tests++; if (nv != 1) begin fails++; $display("FAIL stray_valid_count got %0d want 1", nv); end
      tests++; if (lat != 4) begin fails++; $display("FAIL stray_latch_cycles got %0d want 4", lat); end
      tests++; if (buttons !== 16'h3C5A) begin fails++; $display("FAIL stray_buttons got %h want 3c5a", buttons); end
      pad = 16'h0F0F;
      frame(-10, -1, 16'h0, v_at, lat, falls, lows, nv, ch);
      tests++; if (v_at != 97) begin fails++; $display("FAIL after_stray_valid_at got %0d want 97", v_at); end
      tests++; if (buttons !== 16'h0F0F) begin fails++; $display("FAIL after_stray_buttons got %h want 0f0f", buttons); end
   endtask
   task automatic test_auto;
      logic [15:0] w [6] = '{16'h1111, 16'h8001, 16'h7FFE, 16'hDEAD, 16'hBEEF, 16'h5555};
      int n, nv, k;
      pad = w[0];
      n = 0; nv = 0; k = 0;
      @(negedge clk); auto_en = 1'b1;
      while (!valid && n < 400) begin @(negedge clk); n++; end
      tests++; if (!valid) begin fails++; $display("FAIL auto_first_valid got none want pulse within 400"); end
      for (int i = 0; i < 1000; i++) begin
         if (valid) begin
            nv++;
            tests++; if (buttons !== w[k]) begin fails++; $display("FAIL auto_buttons_%0d got %h want %h", k, buttons, w[k]); end
            if (k < 5) k++;
            pad = w[k];
         end
         @(negedge clk);
      end
      auto_en = 1'b0;
      tests++; if (nv != 5) begin fails++; $display("FAIL auto_valid_count got %0d want 5", nv); end
      repeat (150) @(negedge clk);
   endtask
   task automatic test_reset_mid;
      int v_at, lat, falls, lows, nv;
      logic ch;
      pad = 16'hC3A5;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (44) @(negedge clk);
      tests++; if (sclk !== 1'b0) begin fails++; $display("FAIL midreset_pre_sclk got %b want 0", sclk); end
      reset_n = 1'b0;
      #1;
      tests++; if ({latch, sclk, busy, valid} !== 4'b0100) begin fails++; $display("FAIL midreset_ctl got %b want 0100", {latch, sclk, busy, valid}); end
      tests++; if (buttons !== 16'h0) begin fails++; $display("FAIL midreset_buttons got %h want 0000", buttons); end
      @(negedge clk); @(negedge clk); reset_n = 1'b1;
      pad = 16'h6A96;
      frame(-10, -1, 16'h0, v_at, lat, falls, lows, nv, ch);
      tests++; if (v_at != 97) begin fails++; $display("FAIL midreset_next_valid_at got %0d want 97", v_at); end
      tests++; if (buttons !== 16'h6A96) begin fails++; $display("FAIL midreset_next_buttons got %h want 6a96", buttons); end
   endtask
   task automatic test_midframe_change;
      int v_at, lat, falls, lows, nv;
      logic ch;
      pad = 16'h1234;
      frame(-10, 20, 16'hFFFF, v_at, lat, falls, lows, nv, ch);
      tests++; if (buttons !== 16'h1234) begin fails++; $display("FAIL midchange_buttons got %h want 1234", buttons); end
      tests++; if (ch !== 1'b0) begin fails++; $display("FAIL midchange_early_update got %b want 0", ch); end
      tests++; if (nv != 1) begin fails++; $display("FAIL midchange_valid_count got %0d want 1", nv); end
   endtask
   initial begin
      test_reset;
      test_basic;
      test_invert;
      test_busy_drop;
      test_auto;
      test_reset_mid;
      test_midframe_change;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
